imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time programming controller for the CPU's writable instruction memory. It accepts a framed byte stream (length byte, big-endian instruction words, XOR checksum) from the I/O receiver. It assembles 32-bit words and drives the instruction memory write port. It holds the pipeline stalled for the whole load, so fetch never sees a partially written program.

## Interface

- `AW`, default 6: instruction memory address width (word addressed, depth 2^AW); legal range 1..8.
- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-low; sampled on `clk`.
- `start` input 1: begin a load; sampled only in IDLE, DONE, ERR.
- `rx_valid` input 1: byte available on `rx_data`.
- `rx_data` input 8: stream byte.
- `rx_ready` output 1: loader can accept a byte; a byte transfers when `rx_valid && rx_ready`.
- `we` output 1: instruction memory write strobe, one cycle per word.
- `wa` output AW: word address for the write.
- `wd` output 32: instruction word for the write.
- `cpu_hold` output 1: stall/hold request to the pipeline (fetch and PC frozen).
- `busy` output 1: load in progress.
- `done` output 1: one-cycle pulse on successful completion.
- `err` output 1: level; the last load failed.

## Operation

- Frame: `LEN`, `B0..B(4N-1)`, `CHK`.
  - N = `LEN` when `LEN` is 1..2^AW. `LEN` = 0 means N = 2^AW.
  - `LEN` > 2^AW is a length error; only possible when AW < 8.
  - Each word is 4 bytes, MSB first: the first byte goes to bits 31:24.
  - `CHK` = XOR of all 4N data bytes. `LEN` is excluded.
- States: IDLE, LEN, DATA, CHK, DONE, ERR.
  - IDLE -> LEN on `start`.
  - LEN -> DATA on accepted legal `LEN`. LEN -> ERR on an illegal `LEN`.
  - DATA -> CHK after the 4th byte of word N-1 is accepted.
  - CHK -> DONE when the accepted byte equals the running XOR. CHK -> ERR otherwise.
  - DONE -> LEN if `start` is asserted, else IDLE; DONE lasts exactly one cycle.
  - ERR -> LEN on `start`. ERR otherwise holds.
- Outputs decoded from registered state:
  - `rx_ready` = `busy` = state in {LEN, DATA, CHK}.
  - `cpu_hold` = state in {LEN, DATA, CHK, ERR}.
  - `done` = DONE.
  - `err` = ERR.
- Entering LEN clears the word index, byte counter (2 bits), XOR accumulator and shift register.
- Word write:
  - On acceptance of byte 3 of a word, the registers are set as follows: `we`=1, `wa`=word index, `wd`={shift[23:0], rx_data}.
  - The word index then increments.
  - `we` is low in every other cycle.
  - `wa`/`wd` hold their last value when `we`=0.
- `start` while busy is ignored.
- `rx_valid` while `rx_ready`=0 is ignored; the loader does not consume the byte.
- Word index width is AW+1, so a count of 2^AW is representable. `wa` is the low AW bits.

## Timing

- Reset (`reset`=0 at an edge): state IDLE. All outputs 0: `rx_ready`, `we`, `wa`, `wd`, `cpu_hold`, `busy`, `done`, `err`.
- `start` high at edge k: LEN from cycle k+1, so `rx_ready` and `cpu_hold` are 1 from cycle k+1.
- One byte can be accepted per cycle; gaps in `rx_valid` stall the loader with no effect on state.
- 4th byte of a word accepted at edge t: `we` is high during cycle t+1 (registered, 1-cycle latency).
- Last data byte accepted at edge t: CHK from t+1, so the final `we` coincides with the first CHK cycle.
  - The earliest `CHK` byte is accepted at t+1.
  - DONE occurs in cycle t+2, and `cpu_hold` is 0 from cycle t+2.
  - The final write always precedes `cpu_hold` release.
- Minimum load time for N words: 4N+3 cycles from `start`.
- Reset mid-load:
  - Returns to IDLE immediately and `cpu_hold` drops.
  - Words already written stay in memory, so the program may be partial.
  - The next `start` begins a fresh frame.
- ERR leaves written words in place; `cpu_hold` stays 1 until a successful reload or reset.

## Test plan

- **Reset:** hold `reset`=0 for 2 cycles with `rx_valid`=1 and `start`=1 -> all outputs 0, no `we`.
- **Good load, AW=6:** `start`; stream 02, 20,08,00,05, 20,09,00,0C, 08, with one idle cycle between bytes 2 and 3 ->
  - `we` with `wa`=0, `wd`=0x20080005.
  - `we` with `wa`=1, `wd`=0x2009000C.
  - `done` pulse 1 cycle after the checksum is accepted; `cpu_hold` falls the same cycle; `err`=0.
- **Bad checksum:** same frame with `CHK`=09 ->
  - Both writes occur, then `err`=1, `cpu_hold`=1, `rx_ready`=0, and the state holds.
  - `start` -> `err`=0, `rx_ready`=1 next cycle.
- **Length error:** `LEN`=0x41 with AW=6 -> ERR next cycle, zero `we` pulses, `cpu_hold`=1.
- **Full depth:** `LEN`=00, 256 data bytes back-to-back ->
  - 64 writes with `wa` 0..63 in order.
  - `start` pulses during DATA are ignored.
  - `done` occurs 259 cycles after `start` when the checksum byte arrives immediately.
- **Reset mid-DATA:** `reset`=0 after 6 data bytes -> IDLE, `cpu_hold`=0. A new 1-word frame then writes to `wa`=0 with correct byte alignment.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake and instruction-memory write port of the boot loader.
interface imem_loader_if #(
  parameter int AW = 6
);
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          we;
  logic [AW-1:0] wa;
  logic [31:0]   wd;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, we, wa, wd
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, we, wa, wd
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses LEN / big-endian words / XOR checksum
// frames, writes each word to imem and keeps the CPU held for the whole load.
module imem_loader #(
  parameter int AW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  imem_loader_if.master  bus,
  output logic           cpu_hold,
  output logic           busy,
  output logic           done,
  output logic           err
);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE, S_ERR} state_t;

  localparam logic [8:0]  DEPTH   = 9'(1 << AW);
  localparam logic [AW:0] IDX_ONE = (AW+1)'(1);

  state_t        state, state_nxt;
  logic [AW:0]   widx;       // one bit wider than wa so a count of 2^AW fits
  logic [AW:0]   nwords_m1;
  logic [1:0]    bcnt;
  logic [7:0]    xacc;
  logic [23:0]   shift;
  logic          we_q;
  logic [AW-1:0] wa_q;
  logic [31:0]   wd_q;

  logic          accept;
  logic          len_ok;
  logic          last_byte;
  logic [8:0]    len_ext;

  assign busy     = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
  assign cpu_hold = busy || (state == S_ERR);
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERR);

  assign bus.rx_ready = busy;
  assign bus.we       = we_q;
  assign bus.wa       = wa_q;
  assign bus.wd       = wd_q;

  assign accept    = bus.rx_valid && busy;
  assign len_ext   = {1'b0, bus.rx_data};
  // LEN=0 encodes a full-depth load, so only values above the depth are illegal.
  assign len_ok    = (len_ext <= DEPTH);
  assign last_byte = (bcnt == 2'd3) && (widx == nwords_m1);

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_LEN;
      S_LEN:  if (accept) state_nxt = len_ok ? S_DATA : S_ERR;
      S_DATA: if (accept && last_byte) state_nxt = S_CHK;
      S_CHK:  if (accept) state_nxt = (bus.rx_data == xacc) ? S_DONE : S_ERR;
      S_DONE: state_nxt = start ? S_LEN : S_IDLE;
      S_ERR:  if (start) state_nxt = S_LEN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      widx      <= '0;
      nwords_m1 <= '0;
      bcnt      <= '0;
      xacc      <= '0;
      shift     <= '0;
      we_q      <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
    end else begin
      state <= state_nxt;
      we_q  <= 1'b0;

      if (state_nxt == S_LEN && state != S_LEN) begin
        widx  <= '0;
        bcnt  <= '0;
        xacc  <= '0;
        shift <= '0;
      end

      if (accept && state == S_LEN && len_ok) begin
        nwords_m1 <= (AW+1)'((len_ext == 9'd0) ? DEPTH - 9'd1 : len_ext - 9'd1);
      end

      if (accept && state == S_DATA) begin
        shift <= {shift[15:0], bus.rx_data};
        xacc  <= xacc ^ bus.rx_data;
        bcnt  <= bcnt + 2'd1;
        if (bcnt == 2'd3) begin
          we_q <= 1'b1;
          wa_q <= widx[AW-1:0];
          wd_q <= {shift, bus.rx_data};
          widx <= widx + IDX_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, directed corner cases and
// random frames compared against a frame-level reference model.
module tb_imem_loader;

  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_hold, busy, done, err;

  imem_loader_if #(.AW(AW)) bus ();

  imem_loader #(.AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int we_nohold = 0;
  int done_cyc  = 0;

  logic [AW+31:0] wr_q[$];
  logic [AW+31:0] exp_wr[$];
  logic [7:0]     frm[$];
  bit             exp_done;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      wr_q.push_back({bus.wa, bus.wd});
      if (cpu_hold !== 1'b1) we_nohold++;
    end
    if (done === 1'b1) done_cyc = cyc;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit rdy;
    int t;
    repeat (gap) tick();
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    rdy = 1'b0;
    t   = 0;
    while (!rdy && t < 64) begin
      @(negedge clk);
      rdy = bus.rx_ready;
      @(posedge clk);
      #1;
      t++;
    end
    bus.rx_valid = 1'b0;
    if (!rdy) check("byte_accept_timeout", 64'd0, 64'd1);
  endtask

  // Reference model: expected writes and outcome derived directly from the frame.
  function automatic void model();
    int n;
    logic [7:0] x;
    exp_wr.delete();
    exp_done = 1'b0;
    n = (frm[0] == 8'd0) ? DEPTH : int'(frm[0]);
    if (n > DEPTH) return;
    for (int w = 0; w < n; w++)
      exp_wr.push_back({AW'(w), frm[1+4*w], frm[2+4*w], frm[3+4*w], frm[4+4*w]});
    x = 8'd0;
    for (int i = 1; i <= 4*n; i++) x ^= frm[i];
    exp_done = (frm[4*n+1] == x);
  endfunction

  function automatic void build_frame(input logic [7:0] len, input int seed,
                                      input logic [7:0] flip, input bit rnd);
    int n;
    logic [7:0] x, b;
    frm.delete();
    frm.push_back(len);
    n = (len == 8'd0) ? DEPTH : int'(len);
    if (n > DEPTH) return;
    x = 8'd0;
    for (int i = 0; i < 4*n; i++) begin
      b = rnd ? 8'($urandom) : 8'(seed + 13*i);
      frm.push_back(b);
      x ^= b;
    end
    frm.push_back(x ^ flip);
  endfunction

  task automatic run_frame(input string name, input int gap_max, input bit with_start);
    wr_q.delete();
    model();
    if (with_start) do_start();
    foreach (frm[i]) send_byte(frm[i], (gap_max == 0) ? 0 : $urandom_range(gap_max, 0));
    @(negedge clk);
    check({name, " done"}, 64'(done), 64'(exp_done));
    @(negedge clk);
    check({name, " done_one_cycle"}, 64'(done), 64'd0);
    check({name, " err"}, 64'(err), 64'(!exp_done));
    check({name, " cpu_hold"}, 64'(cpu_hold), 64'(!exp_done));
    check({name, " nwrites"}, 64'(wr_q.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
      check({name, " write"}, 64'(wr_q[i]), 64'(exp_wr[i]));
  endtask

  typedef struct {
    logic [7:0] len;
    logic [7:0] flip;
    int         gap;
    int         exp_writes;
    bit         exp_ok;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'h02, 8'h00, 0, 2,  1'b1};
    vecs[1] = '{8'h02, 8'h01, 0, 2,  1'b0};
    vecs[2] = '{8'h01, 8'h00, 2, 1,  1'b1};
    vecs[3] = '{8'h41, 8'h00, 0, 0,  1'b0};
    vecs[4] = '{8'h40, 8'h00, 0, 64, 1'b1};
    vecs[5] = '{8'hFF, 8'h00, 1, 0,  1'b0};
    vecs[6] = '{8'h03, 8'h80, 1, 3,  1'b0};

    // Reset with start and rx_valid asserted: nothing may leak through.
    reset = 1'b0;
    start = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h02;
    tick();
    tick();
    check("rst rx_ready", 64'(bus.rx_ready), 64'd0);
    check("rst we",       64'(bus.we),       64'd0);
    check("rst wa",       64'(bus.wa),       64'd0);
    check("rst wd",       64'(bus.wd),       64'd0);
    check("rst cpu_hold", 64'(cpu_hold),     64'd0);
    check("rst busy",     64'(busy),         64'd0);
    check("rst done",     64'(done),         64'd0);
    check("rst err",      64'(err),          64'd0);
    check("rst no writes", 64'(wr_q.size()), 64'd0);
    reset = 1'b1;
    start = 1'b0;
    bus.rx_valid = 1'b0;
    tick();

    // Directed good load with an idle cycle before the third stream byte.
    frm = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0C, 8'h08};
    wr_q.delete();
    do_start();
    check("good rx_ready after start", 64'(bus.rx_ready), 64'd1);
    check("good cpu_hold after start", 64'(cpu_hold), 64'd1);
    foreach (frm[i]) send_byte(frm[i], (i == 3) ? 1 : 0);
    @(negedge clk);
    check("good done", 64'(done), 64'd1);
    check("good hold released", 64'(cpu_hold), 64'd0);
    check("good err", 64'(err), 64'd0);
    check("good nwrites", 64'(wr_q.size()), 64'd2);
    if (wr_q.size() >= 2) begin
      check("good word0", 64'(wr_q[0]), {26'd0, 6'd0, 32'h20080005});
      check("good word1", 64'(wr_q[1]), {26'd0, 6'd1, 32'h2009000C});
    end
    @(negedge clk);
    check("good done one cycle", 64'(done), 64'd0);

    // Bad checksum: writes happen, ERR holds until start.
    frm[9] = 8'h09;
    run_frame("badchk", 0, 1'b1);
    check("badchk rx_ready", 64'(bus.rx_ready), 64'd0);
    repeat (3) tick();
    check("badchk err holds", 64'(err), 64'd1);
    check("badchk hold holds", 64'(cpu_hold), 64'd1);
    do_start();
    check("restart err cleared", 64'(err), 64'd0);
    check("restart rx_ready", 64'(bus.rx_ready), 64'd1);
    build_frame(8'h01, 77, 8'h00, 1'b0);
    run_frame("restart", 0, 1'b0);

    // Vector table.
    for (int i = 0; i < 7; i++) begin
      build_frame(vecs[i].len, i*17 + 1, vecs[i].flip, 1'b0);
      run_frame($sformatf("vec%0d", i), vecs[i].gap, 1'b1);
      check($sformatf("vec%0d table writes", i), 64'(wr_q.size()), 64'(vecs[i].exp_writes));
      check($sformatf("vec%0d table err", i), 64'(err), 64'(!vecs[i].exp_ok));
    end

    // Full depth, back-to-back, with start pulses ignored during DATA.
    build_frame(8'h00, 3, 8'h00, 1'b0);
    model();
    wr_q.delete();
    done_cyc = 0;
    do_start();
    begin
      int start_cyc;
      start_cyc = cyc - 1;
      foreach (frm[i]) begin
        start = (i >= 100 && i < 103);
        send_byte(frm[i], 0);
      end
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("full done latency", 64'(done_cyc - start_cyc), 64'd259);
    end
    check("full nwrites", 64'(wr_q.size()), 64'(DEPTH));
    for (int i = 0; i < DEPTH && i < wr_q.size(); i++)
      check("full write", 64'(wr_q[i]), 64'(exp_wr[i]));

    // Reset in the middle of DATA, then a fresh one-word frame.
    build_frame(8'h02, 9, 8'h00, 1'b0);
    do_start();
    for (int i = 0; i < 7; i++) send_byte(frm[i], 0);
    reset = 1'b0;
    tick();
    check("midrst cpu_hold", 64'(cpu_hold), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    reset = 1'b1;
    tick();
    frm = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    run_frame("after_rst", 0, 1'b1);
    if (wr_q.size() >= 1) check("after_rst word", 64'(wr_q[0]), {26'd0, 6'd0, 32'hAABBCCDD});

    // Random frames: legal and illegal lengths, corrupted checksums, stalls.
    for (int k = 0; k < 24; k++) begin
      int r;
      logic [7:0] len, flip;
      r = $urandom_range(9, 0);
      if (r == 0)      len = 8'($urandom_range(255, DEPTH + 1));
      else if (r == 1) len = 8'd0;
      else             len = 8'($urandom_range(6, 1));
      flip = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      build_frame(len, 0, flip, 1'b1);
      run_frame($sformatf("rnd%0d", k), 2, 1'b1);
    end

    check("we outside cpu_hold", 64'(we_nohold), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
